// File: rtl/full_subtractor.sv
// Registered WIDTH-bit subtractor: {Bout, D} = a - b - Bin, built from a
// ripple chain of 1-bit full-subtractor cells. One cycle of latency, with a
// valid qualifier and a synchronous active-high reset.
// Optional feature: define FS_OVF_EN to add the registered signed-overflow
// output ovf. Without it, the port and its logic do not exist.
module full_subtractor #(
  parameter int WIDTH = 1  // legal range 1..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             out_valid
`ifdef FS_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Ripple-chain result, before the output register.
  logic [WIDTH:0]   br;       // br[i] is the borrow into cell i
  logic [WIDTH-1:0] diff;

  // Registered state and its next-state values.
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             valid_q, valid_d;
`ifdef FS_OVF_EN
  logic             ovf_next;
  logic             ovf_q, ovf_d;
`endif

  // Ripple chain of full-subtractor cells, LSB first, seeded with Bin.
  always_comb begin
    // NOTE: give every combinationally assigned signal a default first, so no
    // path through the block leaves it unassigned and a latch is inferred.
    br   = '0;
    diff = '0;
    br[0] = Bin;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end

`ifdef FS_OVF_EN
  // Signed overflow: the operands differ in sign and the result sign differs
  // from the minuend's. This stays exact when Bin is included.
  always_comb begin
    ovf_next = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]);
  end
`endif

  // Next state: load the new result on an accepted input, otherwise hold.
  // Inputs are only looked at when in_valid is high, so X on them while idle
  // never reaches the registers.
  always_comb begin
    d_d     = d_q;
    bout_d  = bout_q;
    valid_d = 1'b0;
`ifdef FS_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (in_valid) begin
      d_d     = diff;
      bout_d  = br[WIDTH];
      valid_d = 1'b1;
`ifdef FS_OVF_EN
      ovf_d   = ovf_next;
`endif
    end
  end

  // Output register. Reset wins over in_valid, so a result accepted on the
  // same edge as reset is discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (rst) begin
      d_q     <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef FS_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      d_q     <= d_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
`ifdef FS_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign D         = d_q;
  assign Bout      = bout_q;
  assign out_valid = valid_q;
`ifdef FS_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor. Three instances (WIDTH 1, 8, 16)
// share the clock and reset. Drivers push expected results to per-instance
// queues, and monitors on the falling edge pop and compare them whenever
// out_valid is high. Hold and reset corners are checked by hand-written
// sequences.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        v1, v8, v16;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        bin1, bin8, bin16;
  logic [0:0]  d1;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        bo1, bo8, bo16;
  logic        ov1, ov8, ov16;
`ifdef FS_OVF_EN
  logic        of1, of8, of16;
`endif

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .Bin(bin1),
    .D(d1), .Bout(bo1), .out_valid(ov1)
`ifdef FS_OVF_EN
    , .ovf(of1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .Bin(bin8),
    .D(d8), .Bout(bo8), .out_valid(ov8)
`ifdef FS_OVF_EN
    , .ovf(of8)
`endif
  );

  full_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .Bin(bin16),
    .D(d16), .Bout(bo16), .out_valid(ov16)
`ifdef FS_OVF_EN
    , .ovf(of16)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    bit          chk_ovf;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic no_result(input string name);
    total++;
    bad++;
    $display("FAIL %s: out_valid high with nothing pending (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (ov1) begin
      if (q1.size() == 0) no_result("w1 spurious");
      else begin
        e = q1.pop_front();
        check("w1 latency", 64'(cyc), 64'(e.due));
        check("w1 D", 64'(d1), 64'(e.d[0:0]));
        check("w1 Bout", 64'(bo1), 64'(e.bout));
`ifdef FS_OVF_EN
        if (e.chk_ovf) check("w1 ovf", 64'(of1), 64'(e.ovf));
`endif
      end
    end
    if (ov8) begin
      if (q8.size() == 0) no_result("w8 spurious");
      else begin
        e = q8.pop_front();
        check("w8 latency", 64'(cyc), 64'(e.due));
        check("w8 D", 64'(d8), 64'(e.d[7:0]));
        check("w8 Bout", 64'(bo8), 64'(e.bout));
`ifdef FS_OVF_EN
        if (e.chk_ovf) check("w8 ovf", 64'(of8), 64'(e.ovf));
`endif
      end
    end
    if (ov16) begin
      if (q16.size() == 0) no_result("w16 spurious");
      else begin
        e = q16.pop_front();
        check("w16 latency", 64'(cyc), 64'(e.due));
        check("w16 D", 64'(d16), 64'(e.d));
        check("w16 Bout", 64'(bo16), 64'(e.bout));
`ifdef FS_OVF_EN
        if (e.chk_ovf) check("w16 ovf", 64'(of16), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    tick();
  endtask

  // Stimulus tables
  typedef struct {
    logic [0:0] a, b;
    logic       bin, d, bout, ovf;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bout, ovf;
    bit         chk_ovf;
  } vec8_t;

  vec1_t t1[8];
  vec8_t t8[6];

  initial begin
    // WIDTH=1 truth table {a,b,Bin} -> D, Bout, signed overflow
    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // WIDTH=8 directed vectors
    t8[0] = '{8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1};
    t8[1] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};
    t8[2] = '{8'hFF, 8'h0F, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
    t8[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1};
    t8[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1};
    t8[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    idle();
    idle();
    // Reset state
    check("rst w1 D", 64'(d1), 64'd0);
    check("rst w8 D", 64'(d8), 64'd0);
    check("rst w16 D", 64'(d16), 64'd0);
    check("rst Bout", 64'({bo1, bo8, bo16}), 64'd0);
    check("rst out_valid", 64'({ov1, ov8, ov16}), 64'd0);
`ifdef FS_OVF_EN
    check("rst ovf", 64'({of1, of8, of16}), 64'd0);
`endif
    rst = 1'b0;
    idle();

    // WIDTH=1 truth table, back-to-back
    foreach (t1[i]) begin
      q1.push_back('{d: 16'(t1[i].d), bout: t1[i].bout, ovf: t1[i].ovf, chk_ovf: 1'b1, due: cyc + 1});
      v1 = 1'b1; a1 = t1[i].a; b1 = t1[i].b; bin1 = t1[i].bin;
      tick();
    end
    idle();

    // WIDTH=8 directed vectors, back-to-back
    foreach (t8[i]) begin
      q8.push_back('{d: 16'(t8[i].d), bout: t8[i].bout, ovf: t8[i].ovf, chk_ovf: t8[i].chk_ovf, due: cyc + 1});
      v8 = 1'b1; a8 = t8[i].a; b8 = t8[i].b; bin8 = t8[i].bin;
      tick();
    end
    idle();

    // Hold: one result, then three idle cycles with toggling inputs
    q8.push_back('{d: 16'h00FE, bout: 1'b1, ovf: 1'b0, chk_ovf: 1'b1, due: cyc + 1});
    v8 = 1'b1; a8 = 8'h05; b8 = 8'h07; bin8 = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      check("hold D", 64'(d8), 64'hFE);
      check("hold Bout", 64'(bo8), 64'd1);
      check("hold out_valid", 64'(ov8), 64'd0);
`ifdef FS_OVF_EN
      check("hold ovf", 64'(of8), 64'd0);
`endif
    end
    // X on the inputs while idle must not disturb the held value
    v8 = 1'b0; a8 = 'x; b8 = 'x; bin8 = 1'bx;
    tick();
    check("hold x D", 64'(d8), 64'hFE);
    check("hold x Bout", 64'(bo8), 64'd1);

    // Reset on the cycle after an accepted input clears the result
    q8.push_back('{d: 16'h00EF, bout: 1'b0, ovf: 1'b0, chk_ovf: 1'b1, due: cyc + 1});
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; bin8 = 1'b1;
    tick();
    v8 = 1'b0; rst = 1'b1;
    tick();
    check("rst-after D", 64'(d8), 64'd0);
    check("rst-after Bout", 64'(bo8), 64'd0);
    check("rst-after out_valid", 64'(ov8), 64'd0);
    // Reset and in_valid on the same edge: reset wins, input discarded
    v8 = 1'b1; a8 = 8'h05; b8 = 8'h07; bin8 = 1'b0;
    tick();
    check("rst-same D", 64'(d8), 64'd0);
    check("rst-same Bout", 64'(bo8), 64'd0);
    check("rst-same out_valid", 64'(ov8), 64'd0);
    rst = 1'b0;
    idle();
    check("post-rst out_valid", 64'(ov8), 64'd0);

    // WIDTH=16 random vectors with occasional idle gaps
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      logic [16:0] r;
      int          sres;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n % 97 == 0) begin ra = 16'h8000; rb = 16'h0000; rbin = 1'b1; end
      if (n % 89 == 0) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
      r = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      sres = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      q16.push_back('{d: r[15:0], bout: r[16], ovf: (sres > 32767) || (sres < -32768),
                      chk_ovf: 1'b1, due: cyc + 1});
      v16 = 1'b1; a16 = ra; b16 = rb; bin16 = rbin;
      tick();
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    idle();

    // Every pushed result must have come out
    check("w1 leftovers", 64'(q1.size()), 64'd0);
    check("w8 leftovers", 64'(q8.size()), 64'd0);
    check("w16 leftovers", 64'(q16.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
